// File: rtl/monster_wave_ctrl.sv
// Purpose: per-stage monster sequencer; releases slots on a fixed cadence,
//          seeds each slot's RNG, arbitrates one weapon hit per swing,
//          counts kills and flags stage-clear.
// Latency: all outputs registered; hit_grant_o follows its candidate cycle
//          by one clock, a stage change clears outputs on the next clock.
// Backpressure: none; level inputs are sampled every cycle, nothing stalls.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   stage_i             current stage (0, e, f are non-playable)
//   attack_active_i     weapon swing in progress (level)
//   slot_hit_i          raw weapon/monster overlap per slot
//   slot_dead_i         per-slot is_dead
//   slot_state_i        per-slot 4-bit state, slot i at [4i+3:4i]
//   slot_enable_o       slot released and live in this stage
//   hit_grant_o         one-hot, one-cycle weapon-collision grant
//   seed_bus_o          per-slot 13-bit seed, slot i at [13i+12:13i]
//   kill_count_o        kills this stage, saturating at 255
//   stage_clear_o       current stage cleared
//   ctrl_state_o        FSM state for debug
module monster_wave_ctrl #(
  parameter int          N_SLOTS     = 4,
  parameter logic [15:0] SPAWN_GAP   = 16'd200,
  parameter logic [12:0] SEED_STRIDE = 13'd617
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             stage_i,
  input  logic                   attack_active_i,
  input  logic [N_SLOTS-1:0]     slot_hit_i,
  input  logic [N_SLOTS-1:0]     slot_dead_i,
  input  logic [4*N_SLOTS-1:0]   slot_state_i,
  output logic [N_SLOTS-1:0]     slot_enable_o,
  output logic [N_SLOTS-1:0]     hit_grant_o,
  output logic [13*N_SLOTS-1:0]  seed_bus_o,
  output logic [7:0]             kill_count_o,
  output logic                   stage_clear_o,
  output logic [1:0]             ctrl_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SPAWN  = 2'd1,
    ACTIVE = 2'd2,
    CLEAR  = 2'd3
  } state_e;

  localparam logic [3:0]         N_SLOTS_W = 4'(N_SLOTS);
  localparam logic [N_SLOTS-1:0] ONE_N     = N_SLOTS'(1);

  state_e                  state_q;
  logic [3:0]              stage_q;
  logic                    attack_q;
  logic                    armed_q;
  logic [N_SLOTS-1:0]      slot_enable_q;
  logic [N_SLOTS-1:0]      hit_grant_q;
  logic [13*N_SLOTS-1:0]   seed_q;
  logic [7:0]              kill_q;
  logic                    stage_clear_q;
  logic [15:0]             gap_q;
  logic [3:0]              idx_q;

  logic                    playable;
  logic [3:0]              target;
  logic                    leave;
  logic                    attack_rise;
  logic [N_SLOTS-1:0]      cands;
  logic [N_SLOTS-1:0]      grant_d;
  logic                    grant_ok;
  logic [N_SLOTS-1:0]      slot_done;
  logic                    all_done;
  logic [13*N_SLOTS-1:0]   seed_d;

  assign playable    = !((stage_i == 4'h0) || (stage_i == 4'he) || (stage_i == 4'hf));
  assign target      = (stage_i > N_SLOTS_W) ? N_SLOTS_W : stage_i;

  // Any stage edit (or losing playability) outside IDLE tears the stage down.
  assign leave       = (state_q != IDLE) && ((stage_i != stage_q) || !playable);
  assign attack_rise = attack_active_i && !attack_q;

  // Dead slots are excluded so a corpse can never soak up a swing.
  assign cands    = slot_hit_i & slot_enable_q & ~slot_dead_i;
  assign grant_d  = cands & (~cands + ONE_N);  // isolate lowest set bit
  assign grant_ok = armed_q && (cands != '0) && !leave &&
                    ((state_q == SPAWN) || (state_q == ACTIVE));

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
    logic [12:0] seed_raw;
    assign seed_raw = {stage_i, 9'd0} ^ 13'((g + 1) * SEED_STRIDE);
    // A zero seed would lock an LFSR, so it is nudged to 1.
    assign seed_d[13*g +: 13] = (seed_raw == 13'd0) ? 13'd1 : seed_raw;
    // A slot counts as finished when unused, or dead with its death
    // animation complete (state f).
    assign slot_done[g] = ~slot_enable_q[g] |
                          (slot_dead_i[g] & (slot_state_i[4*g +: 4] == 4'hf));
  end

  assign all_done = &slot_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      stage_q       <= 4'h0;
      attack_q      <= 1'b0;
      armed_q       <= 1'b0;
      slot_enable_q <= '0;
      hit_grant_q   <= '0;
      seed_q        <= '0;
      kill_q        <= 8'd0;
      stage_clear_q <= 1'b0;
      gap_q         <= 16'd0;
      idx_q         <= 4'd0;
    end else begin
      stage_q     <= stage_i;
      attack_q    <= attack_active_i;
      hit_grant_q <= '0;

      // One arm per swing: set on the rising edge, consumed by a grant,
      // dropped when the swing ends.
      if (!attack_active_i) begin
        armed_q <= 1'b0;
      end else if (attack_rise) begin
        armed_q <= 1'b1;
      end else if (grant_ok) begin
        armed_q <= 1'b0;
      end

      if (leave) begin
        state_q       <= IDLE;
        slot_enable_q <= '0;
        kill_q        <= 8'd0;
        stage_clear_q <= 1'b0;
        gap_q         <= 16'd0;
        idx_q         <= 4'd0;
        armed_q       <= 1'b0;
      end else begin
        if (grant_ok) begin
          hit_grant_q <= grant_d;
          if (kill_q != 8'hff) begin
            kill_q <= kill_q + 8'd1;
          end
        end

        case (state_q)
          IDLE: begin
            kill_q        <= 8'd0;
            stage_clear_q <= 1'b0;
            gap_q         <= 16'd0;
            if (playable) begin
              state_q       <= SPAWN;
              seed_q        <= seed_d;
              slot_enable_q <= ONE_N;
              idx_q         <= 4'd1;
            end else begin
              slot_enable_q <= '0;
              idx_q         <= 4'd0;
            end
          end
          SPAWN: begin
            if (idx_q == target) begin
              state_q <= ACTIVE;
            end else if (gap_q == SPAWN_GAP - 16'd1) begin
              slot_enable_q <= slot_enable_q | (ONE_N << idx_q);
              idx_q         <= idx_q + 4'd1;
              gap_q         <= 16'd0;
            end else begin
              gap_q <= gap_q + 16'd1;
            end
          end
          ACTIVE: begin
            if (all_done) begin
              state_q       <= CLEAR;
              stage_clear_q <= 1'b1;
            end
          end
          default: begin
            // CLEAR holds until the stage changes.
          end
        endcase
      end
    end
  end

  assign slot_enable_o = slot_enable_q;
  assign hit_grant_o   = hit_grant_q;
  assign seed_bus_o    = seed_q;
  assign kill_count_o  = kill_q;
  assign stage_clear_o = stage_clear_q;
  assign ctrl_state_o  = state_q;

endmodule
